// File: rtl/eight_bit_pkg.sv
// Shared constants for the eight_bit universal shift register: mode encoding
// and default width.
package eight_bit_pkg;

   localparam int WIDTH_DEFAULT = 8;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage : eight_bit_pkg

// File: rtl/eight_bit_usr_cell.sv
// One bit slice of the universal shift register: 4:1 mode mux feeding a
// flop with synchronous active-high reset.
module usr_cell
   import eight_bit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sel,
   input  logic       from_upper,   // bit i+1, or rghtin at the top end
   input  logic       from_lower,   // bit i-1, or lftin at the bottom end
   input  logic       load_bit,
   output logic       q
);

   logic bit_d;
   logic bit_q;

   always_comb begin
      bit_d = bit_q;
      case (sel)
         SEL_HOLD: bit_d = bit_q;
         SEL_SHR:  bit_d = from_upper;
         SEL_SHL:  bit_d = from_lower;
         SEL_LOAD: bit_d = load_bit;
         default:  bit_d = bit_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign q = bit_q;

endmodule : usr_cell

// File: rtl/eight_bit.sv
// Universal shift register (hold / shift right / shift left / parallel load)
// built from WIDTH single-bit usr_cell slices; out is the registered contents.
module eight_bit
   import eight_bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pload,
   input  logic             lftin,
   input  logic             rghtin,
   input  logic [1:0]       select,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] upper_nb;
   logic [WIDTH-1:0] lower_nb;

   // End cells take the serial inputs in place of the missing neighbour.
   for (genvar i = 0; i < WIDTH; i++) begin : g_nb
      if (i == WIDTH - 1) begin : g_top
         assign upper_nb[i] = rghtin;
      end else begin : g_mid_u
         assign upper_nb[i] = out[i+1];
      end
      if (i == 0) begin : g_bot
         assign lower_nb[i] = lftin;
      end else begin : g_mid_l
         assign lower_nb[i] = out[i-1];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      usr_cell u_cell (
         .clk        (clk),
         .rst        (rst),
         .sel        (select),
         .from_upper (upper_nb[i]),
         .from_lower (lower_nb[i]),
         .load_bit   (pload[i]),
         .q          (out[i])
      );
   end

endmodule : eight_bit

// File: tb/tb_eight_bit.sv
// Scoreboard bench for eight_bit: expected values queued as stimulus is
// driven on the falling edge, popped and compared just after the rising edge.
module tb_eight_bit;
   import eight_bit_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] pload;
   logic       lftin;
   logic       rghtin;
   logic [1:0] select;
   logic [7:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] model;

   eight_bit #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .pload  (pload),
      .lftin  (lftin),
      .rghtin (rghtin),
      .select (select),
      .out    (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: out=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_next(input logic [7:0] prev, input logic r,
                                           input logic [1:0] s, input logic [7:0] p,
                                           input logic li, input logic ri);
      if (r) return 8'h00;
      case (s)
         2'b00:   return prev;
         2'b01:   return {ri, prev[7:1]};
         2'b10:   return {prev[6:0], li};
         default: return p;
      endcase
   endfunction

   // One edge of stimulus; exp is the value required on out after that edge.
   task automatic step(input string tag, input logic r, input logic [1:0] s,
                       input logic [7:0] p, input logic li, input logic ri,
                       input logic [7:0] exp);
      @(negedge clk);
      rst = r; select = s; pload = p; lftin = li; rghtin = ri;
      exp_q.push_back(exp);
      model = exp;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_empty_queue"}, out, 8'hxx);
      end else begin
         check_eq(tag, out, exp_q.pop_front());
      end
   endtask

   initial begin
      logic [7:0] load_vals [4] = '{8'b0001_0001, 8'b1111_0000, 8'b1010_0101, 8'b1111_0000};
      logic [7:0] shr_vals  [5] = '{8'b0111_1000, 8'b0011_1100, 8'b0001_1110,
                                    8'b0000_1111, 8'b0000_0111};
      logic [7:0] shl_vals  [5] = '{8'b0000_1111, 8'b0001_1111, 8'b0011_1111,
                                    8'b0111_1111, 8'b1111_1111};
      rst = 1'b1; select = SEL_LOAD; pload = 8'hA5; lftin = 1'b0; rghtin = 1'b0;
      model = 8'h00;

      step("reset", 1'b1, SEL_LOAD, 8'hA5, 1'b1, 1'b1, 8'h00);

      for (int i = 0; i < 4; i++)
         step("load_seq", 1'b0, SEL_LOAD, load_vals[i], 1'b0, 1'b0, load_vals[i]);

      for (int i = 0; i < 5; i++)
         step("shift_right", 1'b0, SEL_SHR, 8'h00, 1'b1, 1'b0, shr_vals[i]);

      for (int i = 0; i < 5; i++)
         step("shift_left", 1'b0, SEL_SHL, 8'h00, 1'b1, 1'b0, shl_vals[i]);

      step("load_a5", 1'b0, SEL_LOAD, 8'b1010_0101, 1'b0, 1'b0, 8'b1010_0101);
      for (int i = 0; i < 3; i++)
         step("hold", 1'b0, SEL_HOLD, 8'h3C ^ 8'(i * 8'h55), i[0], ~i[0], 8'b1010_0101);
      step("shr_rghtin1", 1'b0, SEL_SHR, 8'hFF, 1'b0, 1'b1, 8'b1101_0010);

      step("shr_ignores_lftin", 1'b0, SEL_SHR, 8'h00, 1'b1, 1'b0, 8'b0110_1001);
      step("shl_ignores_rghtin", 1'b0, SEL_SHL, 8'h00, 1'b0, 1'b1, 8'b1101_0010);

      step("load_03", 1'b0, SEL_LOAD, 8'b0000_0011, 1'b0, 1'b0, 8'b0000_0011);
      step("shl_pre_rst", 1'b0, SEL_SHL, 8'h00, 1'b1, 1'b0, 8'b0000_0111);
      step("shl_pre_rst", 1'b0, SEL_SHL, 8'h00, 1'b1, 1'b0, 8'b0000_1111);
      step("shl_pre_rst", 1'b0, SEL_SHL, 8'h00, 1'b1, 1'b0, 8'b0001_1111);
      step("reset_mid", 1'b1, SEL_SHL, 8'h00, 1'b1, 1'b0, 8'b0000_0000);
      step("shl_post_rst", 1'b0, SEL_SHL, 8'h00, 1'b1, 1'b0, 8'b0000_0001);

      step("load_80", 1'b0, SEL_LOAD, 8'h80, 1'b0, 1'b0, 8'h80);
      step("shl_drop_msb", 1'b0, SEL_SHL, 8'h00, 1'b0, 1'b0, 8'h00);
      step("load_01", 1'b0, SEL_LOAD, 8'h01, 1'b0, 1'b0, 8'h01);
      step("shr_drop_lsb", 1'b0, SEL_SHR, 8'h00, 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 60; i++) begin
         logic       r;
         logic [1:0] s;
         logic [7:0] p;
         logic       li, ri;
         r  = ($urandom_range(0, 15) == 0);
         s  = 2'($urandom_range(0, 3));
         p  = 8'($urandom);
         li = 1'($urandom);
         ri = 1'($urandom);
         step("random", r, s, p, li, ri, ref_next(model, r, s, p, li, ri));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: out=%b expected=end of run", out);
      $fatal(1, "timeout");
   end

endmodule : tb_eight_bit
